// File: rtl/commit_tracer_if.sv
// Commit/debug stream bundle from the CPU to the tracer.
// The CPU side drives it; the tracer side only observes.
interface commit_tracer_if;
    logic        commit;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic        commit_halt;
    logic        commit_reg_we;
    logic [4:0]  commit_reg_wa;
    logic [31:0] commit_reg_wd;
    logic        commit_dmem_we;
    logic [31:0] commit_dmem_wa;
    logic [31:0] commit_dmem_wd;

    modport master (
        output commit, commit_pc, commit_inst, commit_halt,
        output commit_reg_we, commit_reg_wa, commit_reg_wd,
        output commit_dmem_we, commit_dmem_wa, commit_dmem_wd
    );

    modport slave (
        input commit, commit_pc, commit_inst, commit_halt,
        input commit_reg_we, commit_reg_wa, commit_reg_wd,
        input commit_dmem_we, commit_dmem_wa, commit_dmem_wd
    );
endinterface

// File: rtl/commit_tracer.sv
// Commit stream receiver: statistics, shadow RF, trace FIFO.
// Freezes after a committed HALT until reset.
module commit_tracer #(
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_W       = 32,
    localparam int AW = $clog2(TRACE_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 global_en,
    commit_tracer_if.slave       cm,
    output logic                 halted,
    output logic [CNT_W-1:0]     inst_cnt,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     store_cnt,
    input  logic [4:0]           shadow_ra,
    output logic [31:0]          shadow_rd,
    input  logic                 trace_pop,
    output logic                 trace_valid,
    output logic [31:0]          trace_pc,
    output logic [31:0]          trace_inst,
    output logic [CW-1:0]        trace_count,
    output logic                 trace_overflow
);

    typedef enum logic {RUN, HALTED} state_e;

    state_e state_q, state_d;
    logic   run;
    logic   acc;

    logic [CNT_W-1:0] inst_q, inst_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] st_q, st_d;

    logic [31:0] shadow_q [32];

    logic [63:0]   mem_q [TRACE_DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, full;

    // Store address/data only matter to the CPU; tracer just counts stores.
    logic [63:0] unused_dmem;
    assign unused_dmem = {cm.commit_dmem_wa, cm.commit_dmem_wd};

    assign acc = cm.commit & global_en & run;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next state: only an accepted HALT commit leaves RUN.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && acc && cm.commit_halt)
            state_d = HALTED;
    end

    // State-derived outputs.
    always_comb begin
        run    = (state_q == RUN);
        halted = (state_q == HALTED);
    end

    // Counter next values; all gated by RUN so HALTED freezes them.
    always_comb begin
        inst_d = inst_q;
        cyc_d  = cyc_q;
        st_d   = st_q;
        if (run && global_en)
            cyc_d = cyc_q + CNT_W'(1);
        if (acc)
            inst_d = inst_q + CNT_W'(1);
        if (acc && cm.commit_dmem_we)
            st_d = st_q + CNT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q <= '0;
            cyc_q  <= '0;
            st_q   <= '0;
        end else begin
            inst_q <= inst_d;
            cyc_q  <= cyc_d;
            st_q   <= st_d;
        end
    end

    assign inst_cnt  = inst_q;
    assign cycle_cnt = cyc_q;
    assign store_cnt = st_q;

    // Shadow RF, written only by accepted commits; x0 never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                shadow_q[i] <= '0;
        end else if (acc && cm.commit_reg_we
                     && cm.commit_reg_wa != 5'd0) begin
            shadow_q[cm.commit_reg_wa] <= cm.commit_reg_wd;
        end
    end

    assign shadow_rd = (shadow_ra == 5'd0) ? 32'd0
                                           : shadow_q[shadow_ra];

    assign push = acc;
    assign pop  = trace_pop && (count_q != '0);
    assign full = (count_q == CW'(TRACE_DEPTH));

    // FIFO pointer/count update; a full push without pop drops the oldest.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        if (push && !pop) begin
            if (full) begin
                head_d = head_q + AW'(1);
                ovf_d  = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[tail_q] <= {cm.commit_pc, cm.commit_inst};
    end

    assign trace_valid    = (count_q != '0);
    assign trace_pc       = mem_q[head_q][63:32];
    assign trace_inst     = mem_q[head_q][31:0];
    assign trace_count    = count_q;
    assign trace_overflow = ovf_q;

endmodule

// File: tb/tb_commit_tracer.sv
// Directed bench for commit_tracer.
// Each task drives one scenario and checks its own results.
module tb_commit_tracer;

    logic        clk = 1'b0;
    logic        rst;
    logic        global_en;
    logic        halted;
    logic [31:0] inst_cnt, cycle_cnt, store_cnt;
    logic [4:0]  shadow_ra;
    logic [31:0] shadow_rd;
    logic        trace_pop;
    logic        trace_valid;
    logic [31:0] trace_pc, trace_inst;
    logic [4:0]  trace_count;
    logic        trace_overflow;

    int checks = 0;
    int errors = 0;

    commit_tracer_if ctif();

    commit_tracer #(.TRACE_DEPTH(16), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .global_en      (global_en),
        .cm             (ctif.slave),
        .halted         (halted),
        .inst_cnt       (inst_cnt),
        .cycle_cnt      (cycle_cnt),
        .store_cnt      (store_cnt),
        .shadow_ra      (shadow_ra),
        .shadow_rd      (shadow_rd),
        .trace_pop      (trace_pop),
        .trace_valid    (trace_valid),
        .trace_pc       (trace_pc),
        .trace_inst     (trace_inst),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    task automatic idle_bus();
        ctif.commit         = 1'b0;
        ctif.commit_pc      = '0;
        ctif.commit_inst    = '0;
        ctif.commit_halt    = 1'b0;
        ctif.commit_reg_we  = 1'b0;
        ctif.commit_reg_wa  = '0;
        ctif.commit_reg_wd  = '0;
        ctif.commit_dmem_we = 1'b0;
        ctif.commit_dmem_wa = '0;
        ctif.commit_dmem_wd = '0;
    endtask

    // One commit cycle; returns 1ns after the sampling edge.
    task automatic drive_commit(input logic [31:0] pc,
                                input logic [31:0] inst,
                                input logic halt,
                                input logic we,
                                input logic [4:0] wa,
                                input logic [31:0] wd,
                                input logic dwe);
        ctif.commit         = 1'b1;
        ctif.commit_pc      = pc;
        ctif.commit_inst    = inst;
        ctif.commit_halt    = halt;
        ctif.commit_reg_we  = we;
        ctif.commit_reg_wa  = wa;
        ctif.commit_reg_wd  = wd;
        ctif.commit_dmem_we = dwe;
        ctif.commit_dmem_wa = 32'h8000_0000;
        ctif.commit_dmem_wd = 32'hcafe_f00d;
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        global_en = 1'b0;
        trace_pop = 1'b0;
        shadow_ra = '0;
        idle_bus();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pop_once();
        trace_pop = 1'b1;
        @(posedge clk); #1;
        trace_pop = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (halted !== 1'b0) begin
            errors++; $display("FAIL rst_halted got %h exp 0", halted);
        end
        checks++;
        if (inst_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_inst got %0d exp 0", inst_cnt);
        end
        checks++;
        if (cycle_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_cycle got %0d exp 0", cycle_cnt);
        end
        checks++;
        if (store_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_store got %0d exp 0", store_cnt);
        end
        checks++;
        if (trace_valid !== 1'b0 || trace_count !== 5'd0) begin
            errors++;
            $display("FAIL rst_fifo got v=%b c=%0d exp v=0 c=0",
                     trace_valid, trace_count);
        end
        checks++;
        if (trace_overflow !== 1'b0) begin
            errors++; $display("FAIL rst_ovf got %b exp 0", trace_overflow);
        end
        shadow_ra = 5'd7; #1;
        checks++;
        if (shadow_rd !== 32'd0) begin
            errors++; $display("FAIL rst_shadow got %h exp 0", shadow_rd);
        end
    endtask

    task automatic test_basic_commits();
        logic [31:0] exp_wd [3];
        exp_wd[0] = 32'h11; exp_wd[1] = 32'h22; exp_wd[2] = 32'h33;
        global_en = 1'b1;
        drive_commit(32'h1c00_0000, 32'h0110_0093, 0, 1, 5'd1, 32'h11, 0);
        drive_commit(32'h1c00_0004, 32'h0220_0113, 0, 1, 5'd2, 32'h22, 0);
        drive_commit(32'h1c00_0008, 32'h0330_0193, 0, 1, 5'd3, 32'h33, 0);
        global_en = 1'b0;
        checks++;
        if (inst_cnt !== 32'd3) begin
            errors++; $display("FAIL basic_inst got %0d exp 3", inst_cnt);
        end
        checks++;
        if (cycle_cnt !== 32'd3) begin
            errors++; $display("FAIL basic_cycle got %0d exp 3", cycle_cnt);
        end
        for (int r = 1; r <= 3; r++) begin
            shadow_ra = 5'(r); #1;
            checks++;
            if (shadow_rd !== exp_wd[r-1]) begin
                errors++;
                $display("FAIL basic_shadow r%0d got %h exp %h",
                         r, shadow_rd, exp_wd[r-1]);
            end
        end
        checks++;
        if (trace_count !== 5'd3) begin
            errors++; $display("FAIL basic_count got %0d exp 3", trace_count);
        end
        checks++;
        if (trace_pc !== 32'h1c00_0000 || trace_inst !== 32'h0110_0093) begin
            errors++;
            $display("FAIL basic_head got %h/%h exp 1c000000/01100093",
                     trace_pc, trace_inst);
        end
    endtask

    task automatic test_x0_write();
        global_en = 1'b1;
        drive_commit(32'h1c00_000c, 32'h0000_0013, 0, 1, 5'd0, 32'hdead, 0);
        global_en = 1'b0;
        shadow_ra = 5'd0; #1;
        checks++;
        if (shadow_rd !== 32'd0) begin
            errors++; $display("FAIL x0_read got %h exp 0", shadow_rd);
        end
        checks++;
        if (inst_cnt !== 32'd4) begin
            errors++; $display("FAIL x0_inst got %0d exp 4", inst_cnt);
        end
    endtask

    task automatic test_global_en_gate();
        global_en           = 1'b0;
        ctif.commit         = 1'b1;
        ctif.commit_pc      = 32'hbad0_0000;
        ctif.commit_dmem_we = 1'b1;
        repeat (5) @(posedge clk);
        #1 idle_bus();
        checks++;
        if (cycle_cnt !== 32'd4 || inst_cnt !== 32'd4) begin
            errors++;
            $display("FAIL gate_cnt got cyc=%0d inst=%0d exp 4/4",
                     cycle_cnt, inst_cnt);
        end
        checks++;
        if (trace_count !== 5'd4 || store_cnt !== 32'd0) begin
            errors++;
            $display("FAIL gate_fifo got c=%0d st=%0d exp 4/0",
                     trace_count, store_cnt);
        end
    endtask

    task automatic test_overflow();
        repeat (4) pop_once();
        checks++;
        if (trace_count !== 5'd0 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain got c=%0d v=%b exp 0/0",
                     trace_count, trace_valid);
        end
        global_en = 1'b1;
        for (int i = 0; i < 18; i++)
            drive_commit(32'h2000_0000 + 32'(i * 4), 32'(i), 0, 0, 0, 0, 0);
        global_en = 1'b0;
        checks++;
        if (trace_count !== 5'd16 || trace_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full got c=%0d o=%b exp 16/1",
                     trace_count, trace_overflow);
        end
        checks++;
        if (trace_pc !== 32'h2000_0008) begin
            errors++; $display("FAIL ovf_head got %h exp 20000008", trace_pc);
        end
        checks++;
        if (inst_cnt !== 32'd22) begin
            errors++; $display("FAIL ovf_inst got %0d exp 22", inst_cnt);
        end
        global_en = 1'b1;
        trace_pop = 1'b1;
        drive_commit(32'h2000_0048, 32'd18, 0, 0, 0, 0, 0);
        trace_pop = 1'b0;
        global_en = 1'b0;
        checks++;
        if (trace_count !== 5'd16 || trace_pc !== 32'h2000_000c) begin
            errors++;
            $display("FAIL pushpop got c=%0d pc=%h exp 16/2000000c",
                     trace_count, trace_pc);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (trace_pc !== 32'h2000_000c + 32'(k * 4)
                || trace_inst !== 32'(k + 3)) begin
                errors++;
                $display("FAIL ovf_order %0d got %h/%h exp %h/%h", k,
                         trace_pc, trace_inst,
                         32'h2000_000c + 32'(k * 4), 32'(k + 3));
            end
            pop_once();
        end
        checks++;
        if (trace_valid !== 1'b0 || trace_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_end got v=%b o=%b exp 0/1",
                     trace_valid, trace_overflow);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        checks++;
        if (trace_overflow !== 1'b0) begin
            errors++; $display("FAIL halt_rstovf got %b exp 0", trace_overflow);
        end
        global_en = 1'b1;
        for (int i = 0; i < 6; i++)
            drive_commit(32'h3000_0000 + 32'(i * 4), 32'h13, 0, 0, 0, 0, 0);
        drive_commit(32'h3000_0018, 32'h0010_0073, 1, 1, 5'd5, 32'h77, 0);
        drive_commit(32'h3000_001c, 32'h13, 0, 1, 5'd6, 32'h66, 0);
        drive_commit(32'h3000_0020, 32'h13, 0, 0, 0, 0, 1);
        drive_commit(32'h3000_0024, 32'h13, 0, 1, 5'd6, 32'h66, 0);
        drive_commit(32'h3000_0028, 32'h13, 0, 0, 0, 0, 0);
        global_en = 1'b0;
        checks++;
        if (halted !== 1'b1) begin
            errors++; $display("FAIL halt_flag got %b exp 1", halted);
        end
        checks++;
        if (inst_cnt !== 32'd7 || cycle_cnt !== 32'd7) begin
            errors++;
            $display("FAIL halt_cnt got inst=%0d cyc=%0d exp 7/7",
                     inst_cnt, cycle_cnt);
        end
        checks++;
        if (store_cnt !== 32'd0) begin
            errors++; $display("FAIL halt_store got %0d exp 0", store_cnt);
        end
        shadow_ra = 5'd5; #1;
        checks++;
        if (shadow_rd !== 32'h77) begin
            errors++; $display("FAIL halt_r5 got %h exp 77", shadow_rd);
        end
        shadow_ra = 5'd6; #1;
        checks++;
        if (shadow_rd !== 32'h0) begin
            errors++; $display("FAIL halt_r6 got %h exp 0", shadow_rd);
        end
        checks++;
        if (trace_count !== 5'd7) begin
            errors++; $display("FAIL halt_count got %0d exp 7", trace_count);
        end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (trace_valid !== 1'b1
                || trace_pc !== 32'h3000_0000 + 32'(k * 4)) begin
                errors++;
                $display("FAIL halt_drain %0d got v=%b pc=%h exp 1/%h", k,
                         trace_valid, trace_pc, 32'h3000_0000 + 32'(k * 4));
            end
            pop_once();
        end
        checks++;
        if (trace_valid !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_empty got v=%b h=%b exp 0/1",
                     trace_valid, halted);
        end
        apply_reset();
        shadow_ra = 5'd5; #1;
        checks++;
        if (halted !== 1'b0 || inst_cnt !== 32'd0 || cycle_cnt !== 32'd0
            || store_cnt !== 32'd0 || shadow_rd !== 32'd0
            || trace_count !== 5'd0 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_rst got h=%b i=%0d c=%0d s=%0d r5=%h n=%0d exp zeros",
                     halted, inst_cnt, cycle_cnt, store_cnt, shadow_rd,
                     trace_count);
        end
    endtask

    task automatic test_pop_empty_stores();
        repeat (2) pop_once();
        checks++;
        if (trace_count !== 5'd0 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_pop got c=%0d v=%b exp 0/0",
                     trace_count, trace_valid);
        end
        global_en = 1'b1;
        drive_commit(32'h4000_0000, 32'h00a1_2023, 0, 0, 0, 0, 1);
        drive_commit(32'h4000_0004, 32'h00b1_2223, 0, 0, 0, 0, 1);
        drive_commit(32'h4000_0008, 32'h13, 0, 0, 0, 0, 0);
        global_en = 1'b0;
        checks++;
        if (store_cnt !== 32'd2 || inst_cnt !== 32'd3) begin
            errors++;
            $display("FAIL stores got st=%0d inst=%0d exp 2/3",
                     store_cnt, inst_cnt);
        end
        checks++;
        if (trace_count !== 5'd3 || trace_pc !== 32'h4000_0000) begin
            errors++;
            $display("FAIL empty_after got c=%0d pc=%h exp 3/40000000",
                     trace_count, trace_pc);
        end
        pop_once();
        checks++;
        if (trace_count !== 5'd2 || trace_pc !== 32'h4000_0004) begin
            errors++;
            $display("FAIL empty_pop2 got c=%0d pc=%h exp 2/40000004",
                     trace_count, trace_pc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_commits();
        test_x0_write();
        test_global_en_gate();
        test_overflow();
        test_halt();
        test_pop_empty_stores();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
